cordic_phase: RTL and testbench
===============================

Name: cordic_phase

Overview:
- Iterative vectoring-mode CORDIC directly downstream of the I/Q normalizer.
- Consumes the normalizer's jointly scaled I/Q pair and produces the instantaneous phase as a binary angle for the AIS GMSK demodulation path (phase-difference / discriminator stage).
- Accepts one sample per PAR_ITER+1 cycles.
- A one-entry holding buffer absorbs a sample arriving while busy, because the normalizer has no backpressure input.

Parameters:
- PAR_DATA_WIDTH, 16: width of signed two's-complement I and Q inputs.
- PAR_PHASE_WIDTH, 16: width of the phase output. Full circle = 2^PAR_PHASE_WIDTH; 0x4000 = +90 deg at the default width.
- PAR_ITER, 14: number of micro-rotations. Legal range 4..PAR_PHASE_WIDTH. PAR_ITER+1 <= PAR_DATA_WIDTH is required to keep up with the normalizer.

Ports:
- i_clk    in   1                   clock
- i_rst_n  in   1                   reset; asynchronous, active-low
- i_vld    in   1                   input sample valid, single-cycle pulse
- i_dat_1  in   PAR_DATA_WIDTH      I, signed
- i_dat_2  in   PAR_DATA_WIDTH      Q, signed
- o_rdy    out  1                   1 when idle and holding buffer empty
- o_vld    out  1                   one-cycle result strobe
- o_phase  out  PAR_PHASE_WIDTH     atan2(Q,I), signed binary angle
- o_ovf    out  1                   sticky: a sample was dropped

Behaviour:
- Reset: asynchronous assert and synchronous release. Clears state to IDLE, o_rdy, o_vld, o_ovf, buffer-valid and the iteration counter. Datapath registers are not reset. Reset mid-computation abandons the sample; no o_vld is produced.
- FSM states: IDLE, ROT.
- IDLE:
  - A sample is taken from the buffer if buffer-valid, else from the inputs if i_vld.
  - The accepted sample is pre-rotated into internal registers x, y (PAR_DATA_WIDTH+2 bits, sign-extended) and z (PAR_PHASE_WIDTH+2 bits). State goes to ROT, counter = 0.
- Pre-rotation:
  - x >= 0: (x, y, z) = (I, Q, 0).
  - x < 0 and Q >= 0: (Q, -I, +quarter).
  - x < 0 and Q < 0: (-Q, I, -quarter).
- ROT, iteration k = counter:
  - If y >= 0: x += y>>>k, y -= x>>>k, z += ATAN[k].
  - Else: x -= y>>>k, y += x>>>k, z -= ATAN[k].
  - All three updates use the old x/y values. Shifts are arithmetic.
  - Counter increments. After k = PAR_ITER-1, state goes to IDLE.
- Output:
  - o_vld = 1 on the cycle after the last iteration (registered). Latency is PAR_ITER+1 cycles from accept to o_vld.
  - o_phase = z rounded half-up to PAR_PHASE_WIDTH. It wraps modulo full circle, so +180 deg and -180 deg both read 0x8000.
  - o_phase is held until the next o_vld.
- Back-to-back: the cycle o_vld is high, the FSM is already IDLE and may accept the next sample in that same cycle.
- Holding buffer:
  - i_vld while in ROT with buffer empty: capture into buffer, set buffer-valid.
  - i_vld while in ROT with buffer full: drop the new sample, set o_ovf until reset.
  - i_vld in IDLE with buffer full cannot occur, because the buffer drains on the same IDLE cycle. If i_vld coincides with the buffer drain, the new sample goes into the buffer.
- o_rdy = registered (next state == IDLE and next buffer-valid == 0).
- (0,0) input: y stays 0, so the phase is 0.
- Accuracy: |phase error| <= 2 LSB for PAR_ITER >= PAR_PHASE_WIDTH-2.
- Growth: the guard bits cover CORDIC gain K ≈ 1.6468 times sqrt(2).

Optional Feature:
- Macro: CORDIC_PHASE_MAG_EN.
- When defined:
  - Extra port o_mag, out, PAR_DATA_WIDTH+1, unsigned = final x with the sign bit dropped, i.e. |I,Q|·K, updated with o_vld.
  - Used by the detector as a signal-level indicator.
- When undefined: port absent and x-result register trimmed. Phase behaviour is identical.

Decomposition:
- Package ais_cordic_pkg holds:
  - CORDIC_ATAN_LUT: 32-bit binary-angle constants atan(2^-k), k = 0..31, with 2^32 = full circle; ATAN[0] = 0x20000000.
  - Quarter/half-turn constants.
  - A function truncating/rounding a LUT entry to PAR_PHASE_WIDTH+2 bits.
  - FSM state typedef.
- Sub-module cordic_phase_iter: one combinational micro-rotation (x, y, z, k in; x, y, z out). It is instantiated once and reused every cycle.

Test Plan:
- I=0x4000, Q=0 -> one o_vld exactly 15 cycles after the i_vld cycle; o_phase = 0x0000 ±2.
- I=0, Q=0x4000 -> o_phase = 0x4000 ±2. I=0x4000, Q=0x4000 -> 0x2000 ±2. I=0, Q=-0x4000 -> 0xC000 ±2.
- I=-0x4000, Q=0 -> 0x8000 ±2. I=-0x8000, Q=-1 -> ≈0x8000, no overflow in x/y. I=0, Q=0 -> 0x0000.
- Second i_vld 5 cycles after the first -> buffered; two o_vld at +15 and +30; o_ovf stays 0.
- Three i_vld within one computation -> third sample dropped; o_ovf = 1 and sticky; exactly two o_vld.
- i_rst_n low at cycle 7 of a computation -> o_vld, o_rdy, o_ovf go to 0 immediately; no stale o_vld after release. With CORDIC_PHASE_MAG_EN defined, I=0x4000, Q=0 -> o_mag ≈ 0x6967 ±4.

Source files
------------

// File: rtl/ais_cordic_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ais_cordic_pkg : shared constants, FSM type and angle helper for cordic_phase
// Rev 1.0
// ----------------------------------------------------------------------------
package ais_cordic_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ROT  = 1'b1
  } cordic_state_e;

  // Binary angles with 2^32 = full circle
  localparam logic [31:0] CORDIC_HALF_TURN    = 32'h8000_0000;
  localparam logic [31:0] CORDIC_QUARTER_TURN = CORDIC_HALF_TURN >> 1;

  localparam logic [31:0] CORDIC_ATAN_LUT [32] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  // Round a 32-bit binary angle to zw bits (zw < 32), keeping 2^zw = full circle
  function automatic logic [31:0] cordic_angle_round(input logic [31:0] ang, input int zw);
    logic [32:0] sum;
    sum = {1'b0, ang} + (33'd1 << (31 - zw));
    return 32'(sum >> (32 - zw));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_phase_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cordic_phase_iter : one combinational vectoring-mode micro-rotation
// Rev 1.0
// ----------------------------------------------------------------------------
module cordic_phase_iter
  import ais_cordic_pkg::*;
#(
  parameter int PAR_XW = 18,
  parameter int PAR_ZW = 18
) (
  input  logic signed [PAR_XW-1:0] x_i,
  input  logic signed [PAR_XW-1:0] y_i,
  input  logic signed [PAR_ZW-1:0] z_i,
  input  logic        [4:0]        k_i,
  output logic signed [PAR_XW-1:0] x_o,
  output logic signed [PAR_XW-1:0] y_o,
  output logic signed [PAR_ZW-1:0] z_o
);

  logic signed [PAR_XW-1:0] xs_w;
  logic signed [PAR_XW-1:0] ys_w;
  logic signed [PAR_ZW-1:0] atan_w;

  always_comb begin
    xs_w   = x_i >>> k_i;
    ys_w   = y_i >>> k_i;
    atan_w = PAR_ZW'(cordic_angle_round(CORDIC_ATAN_LUT[k_i], PAR_ZW));
    if (!y_i[PAR_XW-1]) begin
      x_o = x_i + ys_w;
      y_o = y_i - xs_w;
      z_o = z_i + atan_w;
    end else begin
      x_o = x_i - ys_w;
      y_o = y_i + xs_w;
      z_o = z_i - atan_w;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cordic_phase.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cordic_phase : iterative vectoring CORDIC, I/Q -> binary-angle phase with a
// one-entry holding buffer. Define CORDIC_PHASE_MAG_EN to add o_mag.  Rev 1.0
// ----------------------------------------------------------------------------
module cordic_phase
  import ais_cordic_pkg::*;
#(
  parameter int PAR_DATA_WIDTH  = 16,
  parameter int PAR_PHASE_WIDTH = 16,
  parameter int PAR_ITER        = 14
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_vld,
  input  logic signed [PAR_DATA_WIDTH-1:0]  i_dat_1,
  input  logic signed [PAR_DATA_WIDTH-1:0]  i_dat_2,
  output logic                              o_rdy,
  output logic                              o_vld,
  output logic        [PAR_PHASE_WIDTH-1:0] o_phase,
`ifdef CORDIC_PHASE_MAG_EN
  output logic        [PAR_DATA_WIDTH:0]    o_mag,
`endif
  output logic                              o_ovf
);

  localparam int XW = PAR_DATA_WIDTH + 2;
  localparam int ZW = PAR_PHASE_WIDTH + 2;
  localparam logic [4:0] LAST_K = 5'(PAR_ITER - 1);
  localparam logic signed [ZW-1:0] QUARTER_Z = ZW'(cordic_angle_round(CORDIC_QUARTER_TURN, ZW));

  cordic_state_e state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          buf_vld_q, buf_vld_d;
  logic          ovf_q, ovf_d;
  logic          vld_q, vld_d;
  logic          rdy_q, rdy_d;
  logic          buf_ld_w, take_w, last_w;

  logic signed [PAR_DATA_WIDTH-1:0]  buf_i_q, buf_q_q, sel_i_w, sel_q_w;
  logic signed [XW-1:0]              x_q, y_q, pre_x_w, pre_y_w, ext_i_w, ext_q_w, iter_x_w, iter_y_w;
  logic signed [ZW-1:0]              z_q, pre_z_w, iter_z_w, z_rnd_w;
  logic        [PAR_PHASE_WIDTH-1:0] phase_q;
  logic                              zero_q;

  assign take_w = (state_q == ST_IDLE) && (buf_vld_q || i_vld);
  assign last_w = (state_q == ST_ROT) && (cnt_q == LAST_K);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      buf_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      vld_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_vld_q <= buf_vld_d;
      ovf_q     <= ovf_d;
      vld_q     <= vld_d;
      rdy_q     <= rdy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_vld_d = buf_vld_q;
    ovf_d     = ovf_q;
    buf_ld_w  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take_w) begin
          state_d = ST_ROT;
          cnt_d   = '0;
        end
        // A buffered sample drains now; a coincident new one refills the buffer
        if (buf_vld_q) begin
          buf_vld_d = i_vld;
          buf_ld_w  = i_vld;
        end
      end
      default: begin
        cnt_d = cnt_q + 5'd1;
        if (last_w) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        if (i_vld) begin
          if (buf_vld_q) begin
            ovf_d = 1'b1;
          end else begin
            buf_vld_d = 1'b1;
            buf_ld_w  = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    vld_d = last_w;
    rdy_d = (state_d == ST_IDLE) && !buf_vld_d;
  end

  always_comb begin
    sel_i_w = buf_vld_q ? buf_i_q : i_dat_1;
    sel_q_w = buf_vld_q ? buf_q_q : i_dat_2;
    ext_i_w = XW'(sel_i_w);
    ext_q_w = XW'(sel_q_w);
    pre_x_w = ext_i_w;
    pre_y_w = ext_q_w;
    pre_z_w = '0;
    if (sel_i_w[PAR_DATA_WIDTH-1]) begin
      if (!sel_q_w[PAR_DATA_WIDTH-1]) begin
        pre_x_w = ext_q_w;
        pre_y_w = -ext_i_w;
        pre_z_w = QUARTER_Z;
      end else begin
        pre_x_w = -ext_q_w;
        pre_y_w = ext_i_w;
        pre_z_w = -QUARTER_Z;
      end
    end
  end

  cordic_phase_iter #(
    .PAR_XW (XW),
    .PAR_ZW (ZW)
  ) u_iter (
    .x_i (x_q),
    .y_i (y_q),
    .z_i (z_q),
    .k_i (cnt_q),
    .x_o (iter_x_w),
    .y_o (iter_y_w),
    .z_o (iter_z_w)
  );

  assign z_rnd_w = iter_z_w + ZW'(2);

  always_ff @(posedge i_clk) begin
    if (buf_ld_w) begin
      buf_i_q <= i_dat_1;
      buf_q_q <= i_dat_2;
    end
    if (take_w) begin
      x_q    <= pre_x_w;
      y_q    <= pre_y_w;
      z_q    <= pre_z_w;
      zero_q <= (sel_i_w == '0) && (sel_q_w == '0);
    end else if (state_q == ST_ROT) begin
      x_q <= iter_x_w;
      y_q <= iter_y_w;
      z_q <= iter_z_w;
    end
    // A zero vector never drives y negative, so its accumulated angle is meaningless
    if (last_w) begin
      phase_q <= zero_q ? '0 : PAR_PHASE_WIDTH'(z_rnd_w >>> 2);
    end
  end

`ifdef CORDIC_PHASE_MAG_EN
  logic [PAR_DATA_WIDTH:0] mag_q;
  always_ff @(posedge i_clk) begin
    if (last_w) begin
      mag_q <= iter_x_w[PAR_DATA_WIDTH:0];
    end
  end
  assign o_mag = mag_q;
`endif

  assign o_rdy   = rdy_q;
  assign o_vld   = vld_q;
  assign o_phase = phase_q;
  assign o_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_phase.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cordic_phase : directed and randomized checks of cordic_phase against an
// atan2-based reference. Rev 1.0
// ----------------------------------------------------------------------------
module tb_cordic_phase;

  localparam int  DW = 16;
  localparam int  PW = 16;
  localparam int  IT = 14;
  localparam real PI = 3.14159265358979;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic vld   = 1'b0;
  logic signed [DW-1:0] di = '0;
  logic signed [DW-1:0] dq = '0;
  logic          rdy, ovld, ovf;
  logic [PW-1:0] phase;
`ifdef CORDIC_PHASE_MAG_EN
  logic [DW:0]   mag;
  logic [DW:0]   mg_q[$];
`endif

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;
  int n_vld = 0;
  logic [PW-1:0] ph_q[$];
  int            tm_q[$];

  logic signed [DW-1:0] dir_i [6] = '{16'sh4000, 16'sh0000, 16'sh4000, 16'sh0000, -16'sh4000, -16'sh8000};
  logic signed [DW-1:0] dir_q [6] = '{16'sh0000, 16'sh4000, 16'sh4000, -16'sh4000, 16'sh0000, -16'sh0001};
  logic [PW-1:0]        dir_e [6] = '{16'h0000, 16'h4000, 16'h2000, 16'hC000, 16'h8000, 16'h8000};

  cordic_phase #(
    .PAR_DATA_WIDTH  (DW),
    .PAR_PHASE_WIDTH (PW),
    .PAR_ITER        (IT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_vld   (vld),
    .i_dat_1 (di),
    .i_dat_2 (dq),
    .o_rdy   (rdy),
    .o_vld   (ovld),
    .o_phase (phase),
`ifdef CORDIC_PHASE_MAG_EN
    .o_mag   (mag),
`endif
    .o_ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ovld) begin
      ph_q.push_back(phase);
      tm_q.push_back(cyc);
`ifdef CORDIC_PHASE_MAG_EN
      mg_q.push_back(mag);
`endif
      n_vld <= n_vld + 1;
    end
  end

  function automatic logic [PW-1:0] ref_phase(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q);
    real a;
    a = $atan2($itor(q), $itor(i)) * 65536.0 / (2.0 * PI);
    return PW'(longint'($floor(a + 0.5)));
  endfunction

  function automatic int ang_dist(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic signed [PW-1:0] d;
    d = a - b;
    return (d < 0) ? -int'(d) : int'(d);
  endfunction

  task automatic rand_vec(output logic signed [DW-1:0] i, output logic signed [DW-1:0] q);
    longint r2;
    do begin
      i  = DW'($urandom);
      q  = DW'($urandom);
      r2 = longint'(i) * longint'(i) + longint'(q) * longint'(q);
    end while (r2 < 64'd419430400);  // radius >= 0x5000
  endtask

  task automatic send(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q, output int c);
    @(posedge clk); #1;
    vld = 1'b1; di = i; dq = q; c = cyc;
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ang(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp, input int tol);
    n_cmp++;
    assert (ang_dist(obs, exp) <= tol) else begin
      n_err++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h +/-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic get_result(input string tag, output logic [PW-1:0] ph, output int t);
    int n = 0;
    while (ph_q.size() == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    assert ((ph_q.size() != 0) === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed no o_vld expected o_vld within 60 cycles", tag);
    end
    if (ph_q.size() != 0) begin
      ph = ph_q.pop_front();
      t  = tm_q.pop_front();
    end else begin
      ph = '0;
      t  = -1;
    end
  endtask

  initial begin
    int c0, c1, t, v0;
    logic [PW-1:0] ph;
    logic signed [DW-1:0] ai, aq, bi, bq, ci, cq;

    #1 rst_n = 1'b0;
    #3;
    check_eq("reset_o_vld", 32'(ovld), 32'd0);
    check_eq("reset_o_rdy", 32'(rdy), 32'd0);
    check_eq("reset_o_ovf", 32'(ovf), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rdy_after_reset", 32'(rdy), 32'd1);

    // Directed angles; the first also pins latency and busy indication
    for (int k = 0; k < 6; k++) begin
      send(dir_i[k], dir_q[k], c0);
      if (k == 0) check_eq("rdy_busy", 32'(rdy), 32'd0);
      get_result($sformatf("dir%0d_vld", k), ph, t);
      if (k == 0) check_eq("latency", 32'(t - c0), 32'd15);
      check_ang($sformatf("dir%0d_phase", k), ph, dir_e[k], 2);
    end

    send('0, '0, c0);
    get_result("zero_vld", ph, t);
    check_eq("zero_phase", 32'(ph), 32'd0);

    for (int k = 0; k < 16; k++) begin
      rand_vec(ai, aq);
      send(ai, aq, c0);
      get_result($sformatf("rand%0d_vld", k), ph, t);
      check_ang($sformatf("rand%0d_phase(I=%0d,Q=%0d)", k, ai, aq), ph, ref_phase(ai, aq), 3);
    end

    // Second sample five cycles after the first goes through the holding buffer
    rand_vec(ai, aq);
    rand_vec(bi, bq);
    send(ai, aq, c0);
    repeat (3) @(posedge clk);
    send(bi, bq, c1);
    get_result("buf_a_vld", ph, t);
    check_eq("buf_a_time", 32'(t - c0), 32'd15);
    check_ang("buf_a_phase", ph, ref_phase(ai, aq), 3);
    get_result("buf_b_vld", ph, t);
    check_eq("buf_b_time", 32'(t - c0), 32'd30);
    check_ang("buf_b_phase", ph, ref_phase(bi, bq), 3);
    check_eq("buf_no_ovf", 32'(ovf), 32'd0);

    // Three samples in one computation: the third is dropped
    rand_vec(ai, aq);
    rand_vec(bi, bq);
    rand_vec(ci, cq);
    v0 = n_vld;
    send(ai, aq, c0);
    send(bi, bq, c1);
    send(ci, cq, c1);
    get_result("ovf_a_vld", ph, t);
    check_ang("ovf_a_phase", ph, ref_phase(ai, aq), 3);
    get_result("ovf_b_vld", ph, t);
    check_ang("ovf_b_phase", ph, ref_phase(bi, bq), 3);
    repeat (40) @(posedge clk);
    #1;
    check_eq("ovf_vld_count", 32'(n_vld - v0), 32'd2);
    check_eq("ovf_set", 32'(ovf), 32'd1);
    send(16'sh4000, 16'sh4000, c0);
    get_result("ovf_sticky_vld", ph, t);
    check_ang("ovf_sticky_phase", ph, 16'h2000, 2);
    check_eq("ovf_sticky", 32'(ovf), 32'd1);

    // Reset at cycle 7 of a computation abandons the sample
    rand_vec(ai, aq);
    send(ai, aq, c0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_o_vld", 32'(ovld), 32'd0);
    check_eq("midrst_o_rdy", 32'(rdy), 32'd0);
    check_eq("midrst_o_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    v0 = n_vld;
    repeat (30) @(posedge clk);
    #1;
    check_eq("midrst_no_stale_vld", 32'(n_vld - v0), 32'd0);
    check_eq("midrst_rdy_back", 32'(rdy), 32'd1);

    rand_vec(ai, aq);
    send(ai, aq, c0);
    get_result("post_rst_vld", ph, t);
    check_eq("post_rst_time", 32'(t - c0), 32'd15);
    check_ang("post_rst_phase", ph, ref_phase(ai, aq), 3);

`ifdef CORDIC_PHASE_MAG_EN
    begin
      real kg;
      int  exp_mag;
      logic [DW:0] m;
      kg = 1.0;
      for (int k = 0; k < IT; k++) kg = kg * $sqrt(1.0 + 1.0 / (4.0 ** k));
      exp_mag = int'($floor(16384.0 * kg + 0.5));
      while (mg_q.size() != 0) void'(mg_q.pop_front());
      send(16'sh4000, 16'sh0000, c0);
      get_result("mag_vld", ph, t);
      m = (mg_q.size() != 0) ? mg_q.pop_front() : '0;
      n_cmp++;
      assert ((int'(m) - exp_mag <= 4) && (exp_mag - int'(m) <= 4)) else begin
        n_err++;
        $error("FAIL mag: observed 0x%0h expected 0x%0h +/-4", m, exp_mag);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
